// File: rtl/iq_alloc_pkg.sv
// iq_alloc_pkg: sizes, index/partition types and partition helpers shared by the IQ allocator files
package iq_alloc_pkg;
    localparam int DEPTH = 32;
    localparam int INDEX = 5;
    localparam int NUM_PARTS = 4;
    localparam int NUM_PARTS_LOG = $clog2(NUM_PARTS);
    localparam int PART_W = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;
    localparam int PART_SIZE = DEPTH / NUM_PARTS;
    localparam int DW = 4;
    localparam int IW = 4;
    localparam int PICK_W = $clog2(DW + 1);

    typedef logic [INDEX-1:0] iqIdx_t;
    typedef logic [PART_W-1:0] iqPart_t;
    typedef enum logic {RUN, DRAIN} alloc_fsm_t;

    function automatic iqPart_t partOf(iqIdx_t idx);
        return iqPart_t'(int'(idx) / PART_SIZE);
    endfunction

    // Per-entry view of a partition mask
    function automatic logic [DEPTH-1:0] part_expand(logic [NUM_PARTS-1:0] mask);
        logic [DEPTH-1:0] m;
        for (int i = 0; i < DEPTH; i++) m[i] = mask[partOf(iqIdx_t'(i))];
        return m;
    endfunction
endpackage

// File: rtl/iq_prio_pick.sv
// iq_prio_pick: chained find-first-set returning the DW lowest set positions of vec and how many exist
module iq_prio_pick
    import iq_alloc_pkg::*;
(
    input  logic [DEPTH-1:0]    vec,
    output logic [DW*INDEX-1:0] idx,
    output logic [PICK_W-1:0]   cnt
);
    logic [DEPTH-1:0] rem;

    always_comb begin
        rem = vec;
        idx = '0;
        cnt = '0;
        for (int k = 0; k < DW; k++) begin
            for (int i = DEPTH - 1; i >= 0; i--)
                if (rem[i]) idx[k*INDEX +: INDEX] = iqIdx_t'(i);
            cnt = cnt + PICK_W'(|rem);
            rem = rem & (rem - DEPTH'(1));
        end
    end
endmodule

// File: rtl/iq_entry_allocator_partitioned.sv
// iq_entry_allocator_partitioned: free-list for the partitioned IQ, all-or-nothing dispatch grants,
// issue-side reclaim and drain-before-disable partition reconfiguration.
module iq_entry_allocator_partitioned
    import iq_alloc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         allocReq_i,
    input  logic [DW-1:0]         dispatchLaneActive_i,
    output logic [DW*INDEX-1:0]   allocAddr_o,
    output logic                  allocGrant_o,
    output logic                  iqFull_o,
    input  logic [IW-1:0]         freeValid_i,
    input  logic [IW*INDEX-1:0]   freeAddr_i,
    input  logic                  flush_i,
    input  logic                  reconfigReq_i,
    input  logic [NUM_PARTS-1:0]  newPartActive_i,
    output logic [NUM_PARTS-1:0]  iqPartitionActive_o,
    output logic                  iqReady_o,
    output logic [INDEX:0]        freeCnt_o
);
    logic [DEPTH-1:0] free_vec, free_next, eligible, alloc_mask, free_mask;
    logic [NUM_PARTS-1:0] part_active, pend_mask, part_next;
    alloc_fsm_t state;
    logic [DW-1:0] req;
    logic [PICK_W-1:0] need, avail;
    logic [PICK_W-1:0] rank [DW];
    logic [DW*INDEX-1:0] pick;
    logic drain_done;

    assign eligible = free_vec & part_expand(part_active);
    assign iqPartitionActive_o = part_active;
    assign iqReady_o = state == RUN;

    iq_prio_pick u_pick (.vec(eligible), .idx(pick), .cnt(avail));

    always_comb begin
        req = allocReq_i & dispatchLaneActive_i;
        need = '0;
        for (int k = 0; k < DW; k++) begin
            rank[k] = need;
            need = need + PICK_W'(req[k]);
        end
        iqFull_o = reset && need != '0 && (state == DRAIN || need > avail);
        allocGrant_o = reset && need != '0 && !iqFull_o && !flush_i;
        allocAddr_o = '0;
        alloc_mask = '0;
        for (int k = 0; k < DW; k++)
            if (allocGrant_o && req[k]) begin
                allocAddr_o[k*INDEX +: INDEX] = pick[rank[k]*INDEX +: INDEX];
                alloc_mask[pick[rank[k]*INDEX +: INDEX]] = 1'b1;
            end
        free_mask = '0;
        for (int k = 0; k < IW; k++)
            if (freeValid_i[k]) free_mask[freeAddr_i[k*INDEX +: INDEX]] = 1'b1;
        free_next = flush_i ? '1 : (free_vec & ~alloc_mask) | free_mask;
        // Drain ends on the edge that frees the last entry of every partition being removed
        drain_done = &(free_next | ~part_expand(part_active & ~pend_mask));
        part_next = (state == DRAIN && drain_done) ? pend_mask : part_active;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            free_vec <= '1;
            part_active <= '1;
            pend_mask <= '1;
            state <= RUN;
            freeCnt_o <= (INDEX+1)'(DEPTH);
        end else begin
            free_vec <= free_next;
            part_active <= part_next;
            freeCnt_o <= (INDEX+1)'($countones(free_next & part_expand(part_next)));
            if (state == RUN && reconfigReq_i) begin
                state <= DRAIN;
                pend_mask <= (newPartActive_i == '0) ? '1 : newPartActive_i;
            end else if (state == DRAIN && drain_done)
                state <= RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush_i) begin
            assert (!(state == RUN && reconfigReq_i) || newPartActive_i != '0);
            assert ((free_mask & free_vec) == '0);
        end
    end
endmodule

// File: tb/tb_iq_entry_allocator_partitioned.sv
// tb_iq_entry_allocator_partitioned: directed vectors; alloc responses go through an expectation queue
// drained by a negedge monitor, registered status is checked directly after each edge.
module tb_iq_entry_allocator_partitioned;
    import iq_alloc_pkg::*;

    logic clk = 0, reset = 0;
    logic [DW-1:0] allocReq_i = '0, dispatchLaneActive_i = '1;
    logic [DW*INDEX-1:0] allocAddr_o;
    logic allocGrant_o, iqFull_o;
    logic [IW-1:0] freeValid_i = '0;
    logic [IW*INDEX-1:0] freeAddr_i = '0;
    logic flush_i = 0, reconfigReq_i = 0;
    logic [NUM_PARTS-1:0] newPartActive_i = '0;
    logic [NUM_PARTS-1:0] iqPartitionActive_o;
    logic iqReady_o;
    logic [INDEX:0] freeCnt_o;

    typedef struct packed {logic g; logic f; logic [DW*INDEX-1:0] a;} resp_t;
    resp_t exp_q[$];
    resp_t e;
    int checks = 0, errors = 0;

    iq_entry_allocator_partitioned dut (
        .clk(clk), .reset(reset), .allocReq_i(allocReq_i), .dispatchLaneActive_i(dispatchLaneActive_i),
        .allocAddr_o(allocAddr_o), .allocGrant_o(allocGrant_o), .iqFull_o(iqFull_o),
        .freeValid_i(freeValid_i), .freeAddr_i(freeAddr_i), .flush_i(flush_i),
        .reconfigReq_i(reconfigReq_i), .newPartActive_i(newPartActive_i),
        .iqPartitionActive_o(iqPartitionActive_o), .iqReady_o(iqReady_o), .freeCnt_o(freeCnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*INDEX-1:0] ad(int a0, int a1, int a2, int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        allocReq_i = '0;
        dispatchLaneActive_i = '1;
        freeValid_i = '0;
        freeAddr_i = '0;
        flush_i = 0;
        reconfigReq_i = 0;
        newPartActive_i = '0;
    endtask

    task automatic alloc(logic [DW-1:0] r, logic [DW-1:0] act, logic g, logic f, logic [DW*INDEX-1:0] a);
        allocReq_i = r;
        dispatchLaneActive_i = act;
        if (g || f) exp_q.push_back(resp_t'{g: g, f: f, a: a});
        step();
    endtask

    always @(negedge clk) begin
        if (reset && (allocGrant_o || iqFull_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp grant %0b full %0b addr %h required no response",
                         allocGrant_o, iqFull_o, allocAddr_o);
            end else begin
                e = exp_q.pop_front();
                if ({allocGrant_o, iqFull_o, allocAddr_o} != e) begin
                    errors++;
                    $display("FAIL alloc_resp grant %0b full %0b addr %h required grant %0b full %0b addr %h",
                             allocGrant_o, iqFull_o, allocAddr_o, e.g, e.f, e.a);
                end
            end
        end
    end

    initial begin
        step();
        step();
        allocReq_i = '1;
        #1;
        chk("rst_free_cnt", int'(freeCnt_o), 32);
        chk("rst_ready", int'(iqReady_o), 1);
        chk("rst_part", int'(iqPartitionActive_o), 15);
        chk("rst_grant", int'(allocGrant_o), 0);
        chk("rst_full", int'(iqFull_o), 0);
        chk("rst_addr", int'(allocAddr_o), 0);
        allocReq_i = '0;
        reset = 1;
        step();

        alloc(4'hF, 4'hF, 1, 0, ad(0, 1, 2, 3));
        chk("cnt_after_first", int'(freeCnt_o), 28);
        for (int i = 1; i < 7; i++) alloc(4'hF, 4'hF, 1, 0, ad(4*i, 4*i+1, 4*i+2, 4*i+3));
        chk("cnt_fill", int'(freeCnt_o), 4);
        alloc(4'h3, 4'hF, 1, 0, ad(28, 29, 0, 0));
        chk("cnt_two_left", int'(freeCnt_o), 2);
        alloc(4'h7, 4'hF, 0, 1, '0);
        chk("cnt_full_no_consume", int'(freeCnt_o), 2);
        alloc(4'hF, 4'h0, 0, 0, '0);
        chk("cnt_inactive_lanes", int'(freeCnt_o), 2);
        alloc(4'h3, 4'h1, 1, 0, ad(30, 0, 0, 0));
        alloc(4'h1, 4'hF, 1, 0, ad(31, 0, 0, 0));
        chk("cnt_empty", int'(freeCnt_o), 0);

        freeValid_i = 4'h1;
        freeAddr_i = ad(5, 0, 0, 0);
        alloc(4'h1, 4'hF, 0, 1, '0);
        chk("cnt_after_free5", int'(freeCnt_o), 1);
        alloc(4'h2, 4'hF, 1, 0, ad(0, 5, 0, 0));
        chk("cnt_reuse5", int'(freeCnt_o), 0);

        flush_i = 1;
        step();
        chk("cnt_flush", int'(freeCnt_o), 32);

        for (int i = 0; i < 4; i++) alloc(4'hF, 4'hF, 1, 0, ad(4*i, 4*i+1, 4*i+2, 4*i+3));
        chk("cnt_16_busy", int'(freeCnt_o), 16);
        freeValid_i = '1;
        freeAddr_i = ad(0, 1, 2, 3);
        step();
        freeValid_i = '1;
        freeAddr_i = ad(4, 5, 6, 7);
        step();
        chk("cnt_8_busy", int'(freeCnt_o), 24);
        reconfigReq_i = 1;
        newPartActive_i = 4'b1101;
        step();
        chk("drain_ready", int'(iqReady_o), 0);
        chk("drain_part_kept", int'(iqPartitionActive_o), 15);
        alloc(4'h1, 4'hF, 0, 1, '0);
        chk("drain_cnt", int'(freeCnt_o), 24);
        freeValid_i = '1;
        freeAddr_i = ad(8, 9, 10, 11);
        reconfigReq_i = 1;
        newPartActive_i = 4'b0001;
        step();
        chk("drain_hold_ready", int'(iqReady_o), 0);
        chk("drain_hold_part", int'(iqPartitionActive_o), 15);
        freeValid_i = '1;
        freeAddr_i = ad(12, 13, 14, 15);
        step();
        chk("drain_done_ready", int'(iqReady_o), 1);
        chk("drain_done_part", int'(iqPartitionActive_o), 13);
        chk("drain_done_cnt", int'(freeCnt_o), 24);
        alloc(4'hF, 4'hF, 1, 0, ad(0, 1, 2, 3));
        alloc(4'hF, 4'hF, 1, 0, ad(4, 5, 6, 7));
        alloc(4'hF, 4'hF, 1, 0, ad(16, 17, 18, 19));
        chk("cnt_skip_part1", int'(freeCnt_o), 12);

        alloc(4'hF, 4'hF, 1, 0, ad(20, 21, 22, 23));
        alloc(4'hF, 4'hF, 1, 0, ad(24, 25, 26, 27));
        chk("cnt_20_busy", int'(freeCnt_o), 4);
        reconfigReq_i = 1;
        newPartActive_i = 4'b0011;
        step();
        chk("drain2_ready", int'(iqReady_o), 0);
        chk("drain2_cnt", int'(freeCnt_o), 4);
        flush_i = 1;
        step();
        chk("flush_drain_ready", int'(iqReady_o), 1);
        chk("flush_drain_part", int'(iqPartitionActive_o), 3);
        chk("flush_drain_cnt", int'(freeCnt_o), 16);
        alloc(4'hF, 4'hF, 1, 0, ad(0, 1, 2, 3));
        chk("cnt_part01", int'(freeCnt_o), 12);

        reconfigReq_i = 1;
        newPartActive_i = 4'b1111;
        step();
        chk("enable_ready_low", int'(iqReady_o), 0);
        chk("enable_cnt_old", int'(freeCnt_o), 12);
        step();
        chk("enable_ready", int'(iqReady_o), 1);
        chk("enable_part", int'(iqPartitionActive_o), 15);
        chk("enable_cnt", int'(freeCnt_o), 28);

        reconfigReq_i = 1;
        newPartActive_i = 4'b1110;
        step();
        chk("drain3_ready", int'(iqReady_o), 0);
        reset = 0;
        step();
        chk("rst_mid_drain_ready", int'(iqReady_o), 1);
        chk("rst_mid_drain_part", int'(iqPartitionActive_o), 15);
        chk("rst_mid_drain_cnt", int'(freeCnt_o), 32);
        reset = 1;
        flush_i = 1;
        alloc(4'h1, 4'hF, 0, 0, '0);
        chk("flush_suppress_cnt", int'(freeCnt_o), 32);
        alloc(4'h1, 4'hF, 1, 0, ad(0, 0, 0, 0));
        alloc(4'hA, 4'hF, 1, 0, ad(0, 1, 0, 2));
        chk("cnt_lane_order", int'(freeCnt_o), 29);

        step();
        chk("resp_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
